// File: rtl/branch_pc_unit.sv
// Program-counter stage: branch evaluation, next-PC selection, PC register and boot hold.
// Optional PC_MISALIGN_TRAP_EN: misaligned targets halt the core instead of being re-aligned.
module branch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_HOLD    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        boot_done,
    input  logic [31:0] branch,
    input  logic [31:0] jal_offset,
    input  logic [31:0] jalr_imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic        running,
    output logic        trap
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_INIT = (BOOT_HOLD != 32'd0) ? ST_BOOT : ST_RUN;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        cond;
    logic [31:0] branch_sext;
    logic [31:0] target;
    logic [31:0] pc_load;
    logic        pc_load_en;
    logic        misaligned;
    logic        unused_branch_hi;

    // Only the 13-bit B-type offset is meaningful; the upper bits are don't-care.
    assign unused_branch_hi = ^branch[31:13];
    assign branch_sext      = {{19{branch[12]}}, branch[12:0]};
    assign pc_plus4         = pc + 32'd4;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data <  rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
    end

    assign taken = is_branch & cond & (state == ST_RUN);

    always_comb begin
        target = pc_plus4;
        if (is_jalr) begin
            target = (rs1_data + jalr_imm) & ~32'h1;
        end else if (is_jal) begin
            target = pc + jal_offset;
        end else if (taken) begin
            target = pc + branch_sext;
        end
    end

    assign misaligned = (target[1:0] != 2'b00);

`ifdef PC_MISALIGN_TRAP_EN
    assign pc_load    = target;
    assign pc_load_en = (state == ST_RUN) & enable & ~misaligned;
`else
    assign pc_load    = target & 32'hFFFF_FFFC;
    assign pc_load_en = (state == ST_RUN) & enable;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: begin
                if (boot_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef PC_MISALIGN_TRAP_EN
                if (enable && misaligned) begin
                    state_next = ST_HALT;
                end
`else
                state_next = ST_RUN;
`endif
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_INIT;
        endcase
    end

    // running mirrors the state being entered so it rises on the BOOT->RUN edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_INIT;
            pc      <= RESET_VECTOR;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == ST_RUN);
            if (pc_load_en) begin
                pc <= pc_load;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trap <= 1'b0;
        end else begin
            trap <= (state_next == ST_HALT);
        end
    end
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit against a behavioural next-PC model.
module tb_branch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable = 1'b0;
    logic        boot_done = 1'b0;
    logic [31:0] branch = '0;
    logic [31:0] jal_offset = '0;
    logic [31:0] jalr_imm = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [2:0]  funct3 = '0;
    logic        is_branch = 1'b0;
    logic        is_jal = 1'b0;
    logic        is_jalr = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        taken;
    logic        running;
    logic        trap;

    int checks = 0;
    int passed = 0;

    logic [31:0] m_pc;
    bit          m_run;
    bit          m_halt;

    always #5 clock = ~clock;

    branch_pc_unit #(.RESET_VECTOR(RV), .BOOT_HOLD(1)) dut (
        .clock(clock), .reset(reset), .enable(enable), .boot_done(boot_done),
        .branch(branch), .jal_offset(jal_offset), .jalr_imm(jalr_imm),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .funct3(funct3),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .running(running), .trap(trap)
    );

    function automatic bit cond_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] sext13(input logic [31:0] v);
        logic [31:0] b;
        b = v & 32'h1FFF;
        if (b >= 32'h1000) b = b - 32'h2000;
        return b;
    endfunction

    function automatic bit exp_taken();
        return m_run && is_branch && cond_ref(funct3, rs1_data, rs2_data);
    endfunction

    task automatic model_reset();
        m_pc = RV;
        m_run = 1'b0;
        m_halt = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (!m_run && !m_halt) begin
            if (boot_done) m_run = 1'b1;
        end else if (m_run && enable) begin
            if (is_jalr) tgt = (rs1_data + jalr_imm) & ~32'h1;
            else if (is_jal) tgt = m_pc + jal_offset;
            else if (is_branch && cond_ref(funct3, rs1_data, rs2_data)) tgt = m_pc + sext13(branch);
            else tgt = m_pc + 4;
`ifdef PC_MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                m_halt = 1'b1;
                m_run = 1'b0;
            end else begin
                m_pc = tgt;
            end
`else
            m_pc = tgt - (tgt % 4);
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic clear_ctrl();
        is_branch = 1'b0;
        is_jal = 1'b0;
        is_jalr = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        clear_ctrl();
        enable = 1'b1;
        is_jalr = 1'b1;
        rs1_data = addr;
        jalr_imm = '0;
        cycle();
        clear_ctrl();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        is_branch = 1'b1;
        funct3 = 3'b000;
        #2;
        checks++; if (pc !== RV) $display("FAIL reset_pc: got %h expected %h", pc, RV); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else passed++;
        checks++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b expected 0", trap); else passed++;
        checks++; if (taken !== 1'b0) $display("FAIL reset_taken: got %b expected 0", taken); else passed++;
        clear_ctrl();
        @(negedge clock) reset = 1'b0;
    endtask

    task automatic test_boot_hold();
        enable = 1'b1;
        boot_done = 1'b0;
        is_branch = 1'b1;
        funct3 = 3'b000;
        rs1_data = 32'd7;
        rs2_data = 32'd7;
        branch = 32'h40;
        for (int unsigned i = 0; i < 5; i++) begin
            cycle();
            checks++; if (pc !== 32'h0) $display("FAIL boot_pc: got %h expected 0", pc); else passed++;
            checks++; if (running !== 1'b0) $display("FAIL boot_running: got %b expected 0", running); else passed++;
            checks++; if (taken !== 1'b0) $display("FAIL boot_taken: got %b expected 0", taken); else passed++;
        end
        clear_ctrl();
        boot_done = 1'b1;
        cycle();
        boot_done = 1'b0;
        checks++; if (running !== 1'b1) $display("FAIL boot_release_running: got %b expected 1", running); else passed++;
        checks++; if (pc !== 32'h0) $display("FAIL boot_release_pc: got %h expected 0", pc); else passed++;
        cycle();
        checks++; if (pc !== 32'h4) $display("FAIL first_step_pc: got %h expected 4", pc); else passed++;
    endtask

    task automatic test_blt();
        jump_to(32'h100);
        is_branch = 1'b1;
        funct3 = 3'b100;
        rs1_data = 32'hFFFF_FFFF;
        rs2_data = 32'h1;
        branch = 32'h1FF8;
        #1;
        checks++; if (taken !== 1'b1) $display("FAIL blt_taken: got %b expected 1", taken); else passed++;
        cycle();
        checks++; if (pc !== 32'hF8) $display("FAIL blt_pc: got %h expected f8", pc); else passed++;
        jump_to(32'h100);
        is_branch = 1'b1;
        funct3 = 3'b110;
        rs1_data = 32'hFFFF_FFFF;
        rs2_data = 32'h1;
        #1;
        checks++; if (taken !== 1'b0) $display("FAIL bltu_taken: got %b expected 0", taken); else passed++;
        cycle();
        checks++; if (pc !== 32'h104) $display("FAIL bltu_pc: got %h expected 104", pc); else passed++;
        clear_ctrl();
    endtask

    task automatic test_priority();
        is_jal = 1'b1;
        is_jalr = 1'b1;
        is_branch = 1'b1;
        rs1_data = 32'h2001;
        jalr_imm = 32'h4;
        jal_offset = 32'h80;
        cycle();
        checks++; if (pc !== 32'h2004) $display("FAIL jalr_priority_pc: got %h expected 2004", pc); else passed++;
        jump_to(32'h40);
        is_jal = 1'b1;
        jal_offset = 32'hFFFF_FF00;
        cycle();
        checks++; if (pc !== 32'hFFFF_FF40) $display("FAIL jal_wrap_pc: got %h expected ffffff40", pc); else passed++;
        checks++; if (pc_plus4 !== 32'hFFFF_FF44) $display("FAIL jal_wrap_plus4: got %h expected ffffff44", pc_plus4); else passed++;
        jump_to(32'hFFFF_FFFC);
        cycle();
        checks++; if (pc !== 32'h0) $display("FAIL pc4_wrap: got %h expected 0", pc); else passed++;
    endtask

    task automatic test_stall();
        jump_to(32'h200);
        enable = 1'b0;
        is_branch = 1'b1;
        funct3 = 3'b000;
        rs1_data = 32'h5;
        rs2_data = 32'h5;
        branch = 32'h40;
        for (int unsigned i = 0; i < 3; i++) begin
            cycle();
            checks++; if (pc !== 32'h200) $display("FAIL stall_pc: got %h expected 200", pc); else passed++;
            checks++; if (taken !== 1'b1) $display("FAIL stall_taken: got %b expected 1", taken); else passed++;
        end
        enable = 1'b1;
        cycle();
        checks++; if (pc !== 32'h240) $display("FAIL stall_release_pc: got %h expected 240", pc); else passed++;
        clear_ctrl();
    endtask

    task automatic test_random();
        logic [31:0] amask;
`ifdef PC_MISALIGN_TRAP_EN
        amask = 32'hFFFF_FFFC;
`else
        amask = 32'hFFFF_FFFF;
`endif
        for (int unsigned i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            is_branch = ($urandom_range(0, 1) == 1);
            is_jal = ($urandom_range(0, 5) == 0);
            is_jalr = ($urandom_range(0, 7) == 0);
            funct3 = 3'($urandom_range(0, 7));
            rs1_data = $urandom;
            rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
            branch = $urandom & amask;
            jal_offset = $urandom & amask;
            jalr_imm = $urandom & amask;
            if (is_jalr) rs1_data = rs1_data & amask;
            #1;
            checks++; if (taken !== exp_taken()) $display("FAIL rand_taken: got %b expected %b", taken, exp_taken()); else passed++;
            checks++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL rand_plus4: got %h expected %h", pc_plus4, m_pc + 32'd4); else passed++;
            cycle();
            checks++; if (pc !== m_pc) $display("FAIL rand_pc: got %h expected %h", pc, m_pc); else passed++;
            checks++; if (running !== m_run) $display("FAIL rand_running: got %b expected %b", running, m_run); else passed++;
        end
        clear_ctrl();
        enable = 1'b1;
    endtask

    task automatic test_misalign();
        logic [31:0] start;
        jump_to(32'h500);
        start = pc;
        enable = 1'b0;
        is_jalr = 1'b1;
        rs1_data = 32'h1000;
        jalr_imm = 32'h2;
        cycle();
        checks++; if (trap !== 1'b0) $display("FAIL misalign_stall_trap: got %b expected 0", trap); else passed++;
        checks++; if (pc !== 32'h500) $display("FAIL misalign_stall_pc: got %h expected 500", pc); else passed++;
        enable = 1'b1;
        cycle();
`ifdef PC_MISALIGN_TRAP_EN
        checks++; if (pc !== start) $display("FAIL misalign_pc: got %h expected %h", pc, start); else passed++;
        checks++; if (trap !== 1'b1) $display("FAIL misalign_trap: got %b expected 1", trap); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL misalign_running: got %b expected 0", running); else passed++;
        clear_ctrl();
        is_branch = 1'b1;
        funct3 = 3'b001;
        rs1_data = 32'h1;
        rs2_data = 32'h2;
        for (int unsigned i = 0; i < 2; i++) begin
            cycle();
            checks++; if (pc !== start) $display("FAIL halt_pc: got %h expected %h", pc, start); else passed++;
            checks++; if (trap !== 1'b1) $display("FAIL halt_trap: got %b expected 1", trap); else passed++;
            checks++; if (taken !== 1'b0) $display("FAIL halt_taken: got %b expected 0", taken); else passed++;
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (trap !== 1'b0) $display("FAIL halt_reset_trap: got %b expected 0", trap); else passed++;
        checks++; if (pc !== RV) $display("FAIL halt_reset_pc: got %h expected %h", pc, RV); else passed++;
        clear_ctrl();
        @(negedge clock) reset = 1'b0;
        boot_done = 1'b1;
        cycle();
        boot_done = 1'b0;
        checks++; if (running !== 1'b1) $display("FAIL halt_reboot_running: got %b expected 1", running); else passed++;
`else
        checks++; if (pc !== 32'h1000) $display("FAIL misalign_pc: got %h expected 1000", pc); else passed++;
        checks++; if (trap !== 1'b0) $display("FAIL misalign_trap: got %b expected 0", trap); else passed++;
        checks++; if (running !== 1'b1) $display("FAIL misalign_running: got %b expected 1", running); else passed++;
`endif
        clear_ctrl();
    endtask

    task automatic test_async_reset();
        jump_to(32'h3C);
        checks++; if (pc !== 32'h3C) $display("FAIL async_setup_pc: got %h expected 3c", pc); else passed++;
        #2 reset = 1'b1;
        model_reset();
        boot_done = 1'b1;
        #1;
        checks++; if (pc !== RV) $display("FAIL async_reset_pc: got %h expected %h", pc, RV); else passed++;
        checks++; if (running !== 1'b0) $display("FAIL async_reset_running: got %b expected 0", running); else passed++;
        checks++; if (trap !== 1'b0) $display("FAIL async_reset_trap: got %b expected 0", trap); else passed++;
        @(negedge clock) reset = 1'b0;
        cycle();
        boot_done = 1'b0;
        checks++; if (running !== 1'b1) $display("FAIL reset_bootdone_running: got %b expected 1", running); else passed++;
        checks++; if (pc !== RV) $display("FAIL reset_bootdone_pc: got %h expected %h", pc, RV); else passed++;
        cycle();
        checks++; if (pc !== RV + 32'd4) $display("FAIL reset_bootdone_step: got %h expected %h", pc, RV + 32'd4); else passed++;
    endtask

    initial begin
        test_reset();
        test_boot_hold();
        test_blt();
        test_priority();
        test_stall();
        test_random();
        test_misalign();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter stage of the single-cycle RISC-V core, directly downstream of the branch-offset generator. Each cycle it does four things:
- evaluates the branch condition for the current instruction;
- selects the next PC from PC+4, the branch target, the JAL target or the JALR target;
- registers that PC and drives instruction fetch;
- holds the core at the reset vector until the UART loader reports that the program image is in memory.

## Interface

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset and during boot hold
- BOOT_HOLD, 1, 1 = wait for boot_done after reset; 0 = enter RUN directly

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  1 = PC advances this edge; 0 = stall, PC and state hold
- boot_done  in  1  UART loader finished; level, sampled only in BOOT
- branch  in  32  B-type byte offset; bits [12:0] used, sign-extended from bit 12, bits [31:13] ignored
- jal_offset  in  32  J-type byte offset, already sign-extended
- jalr_imm  in  32  I-type immediate, already sign-extended
- rs1_data  in  32  register-file operand 1
- rs2_data  in  32  register-file operand 2
- funct3  in  3  branch comparison select
- is_branch  in  1  current instruction is B-type
- is_jal  in  1  current instruction is JAL
- is_jalr  in  1  current instruction is JALR
- pc  out  32  registered program counter; reset RESET_VECTOR
- pc_plus4  out  32  pc + 4, combinational; link value for JAL/JALR
- taken  out  1  combinational; is_branch AND condition true; 0 in BOOT/HALT
- running  out  1  registered; 1 in RUN; reset 0
- trap  out  1  registered; 1 in HALT; reset 0

## Operation

- States: BOOT, RUN, HALT. Reset enters BOOT if BOOT_HOLD=1, RUN if BOOT_HOLD=0.
- BOOT:
  - pc held at RESET_VECTOR; enable ignored.
  - boot_done=1 at an edge moves the state to RUN; pc stays RESET_VECTOR, so the first RUN cycle fetches the reset vector.
- RUN with enable=1: pc <= next_pc at the edge. RUN with enable=0: pc and state unchanged.
- Branch condition by funct3 (signed compares are two's complement):
  - 000 BEQ, rs1 == rs2
  - 001 BNE, rs1 != rs2
  - 100 BLT, signed rs1 < rs2
  - 101 BGE, signed rs1 >= rs2
  - 110 BLTU, unsigned rs1 < rs2
  - 111 BGEU, unsigned rs1 >= rs2
  - 010 and 011: never taken
- next_pc priority, highest first:
  - is_jalr: (rs1_data + jalr_imm) & ~32'h1
  - is_jal: pc + jal_offset
  - taken: pc + sext(branch[12:0])
  - otherwise: pc + 4
  - Lower-priority flags asserted alongside a higher one are ignored.
- All address sums are 32-bit modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and not an error.
- Misaligned target: selected target has bits [1:0] != 0. Handling is set by the configuration macro.
- HALT: pc, taken and running frozen/0; trap=1; leaves only via reset.
- Reset asserted mid-operation, in any state:
  - pc = RESET_VECTOR, running = 0, trap = 0 immediately, without waiting for a clock edge;
  - state returns to BOOT (or RUN if BOOT_HOLD=0) on deassertion.

## Timing

- next_pc and taken are combinational from the current inputs. pc is updated one edge later. Zero-cycle branch penalty (single-cycle core).
- running rises on the same edge that moves BOOT to RUN.
- trap rises on the edge where the misaligned target would have been loaded; pc keeps its old value.
- enable=0 and misaligned target in the same cycle: no trap, since nothing is loaded.
- boot_done sampled high in the same cycle reset deasserts: the BOOT→RUN transition occurs on the first clean edge after deassertion.

## Configuration

- PC_MISALIGN_TRAP_EN defined:
  - misaligned selected target → state HALT, trap=1, pc not updated.
- PC_MISALIGN_TRAP_EN undefined:
  - target bits [1:0] forced to 00 before loading;
  - HALT is unreachable and trap is tied 0.

## Test plan

- Boot hold: reset, BOOT_HOLD=1, 5 edges with boot_done=0 → pc=0, running=0. Raise boot_done → running=1, pc=0. Next edge with enable=1 and no control flags → pc=4.
- BLT signed: pc=0x100, rs1=0xFFFF_FFFF, rs2=1, funct3=100, branch=0x1FF8 (−8) → taken=1, next pc=0xF8. Same operands with BLTU (110) → taken=0, pc=0x104.
- Priority and JALR: is_jal=1 and is_jalr=1, rs1=0x2001, jalr_imm=4 → pc=0x2004, bit 0 cleared. Separately, is_jal only, jal_offset=−0x100 at pc=0x40 → pc=0xFFFF_FF40 (wrap).
- Stall: enable=0 for 3 edges while is_branch taken → pc unchanged. Then enable=1 → pc = branch target.
- Misalign (macro defined): JALR to 0x1002 → pc holds, trap=1 next edge, running=0. Further edges: no change. Assert reset → trap=0 and pc=RESET_VECTOR asynchronously. Macro undefined: same stimulus → pc=0x1000, trap stays 0.
- Async reset mid-run: pc=0x3C, assert reset between edges → pc=RESET_VECTOR before the next edge.
